// File: rtl/riscv_state_pkg.sv
// Shared predictor types: 2-bit counter encodings, predictor FSM states and
// the saturating counter update used when a branch resolves.
package riscv_state_pkg;

  typedef enum logic [1:0] {
    BP_STRONG_NT = 2'b00,
    BP_WEAK_NT   = 2'b01,
    BP_WEAK_T    = 2'b10,
    BP_STRONG_T  = 2'b11
  } bp_cnt_t;

  typedef enum logic {
    BP_ST_INIT = 1'b0,
    BP_ST_RUN  = 1'b1
  } bp_state_t;

  // Move the counter one step toward the resolved direction, saturating at
  // both ends. Bit 1 of the result is the taken prediction.
  function automatic logic [1:0] bp_sat_update(input logic [1:0] cnt,
                                               input logic       taken);
    logic [1:0] res;
    if (taken) begin
      res = (cnt == BP_STRONG_T) ? BP_STRONG_T : cnt + 2'd1;
    end else begin
      res = (cnt == BP_STRONG_NT) ? BP_STRONG_NT : cnt - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/rl_ram_1r1w.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// A same-address read and write return the old contents; callers that need
// write-first behaviour add their own bypass.
module rl_ram_1r1w #(
  parameter int AW    = 12,
  parameter int DW    = 2,
  parameter int DEPTH = 1 << AW
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data
);

  logic [DW-1:0] mem [DEPTH];

  // Write port: one entry per cycle when enabled.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port: registered, holds its value while rd_en is low.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/riscv_bp.sv
// gshare-style branch predictor. The table of 2-bit counters is indexed by
// {global history, PC bits}. After reset the whole table is swept to weak
// not-taken before lookups and updates are honoured.
//
// Update port: no handshake. A write is accepted on every cycle where
// bu_bp_update_i is high and the predictor is running; it is never
// back-pressured and is dropped while the table clear is in progress.
module riscv_bp
  import riscv_state_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BP_GLOBAL_BITS = 2,
  parameter int BP_LOCAL_BITS  = 10,
  parameter int HAS_RVC        = 0
) (
  input  logic                      rst_ni,
  input  logic                      clk_i,
  input  logic                      id_stall_i,
  input  logic [XLEN-1:0]           if_parcel_pc_i,
  input  logic [BP_GLOBAL_BITS-1:0] bu_bp_history_i,
  output logic [1:0]                bp_bp_predict_o,
  output logic [BP_GLOBAL_BITS-1:0] bp_bp_history_o,
  output logic                      bp_init_busy_o,
  input  logic [XLEN-1:0]           ex_pc_i,
  input  logic                      bu_bp_update_i,
  input  logic                      bu_bp_btaken_i,
  input  logic [1:0]                bu_bp_predict_i,
  input  logic [BP_GLOBAL_BITS-1:0] bu_bp_history_update_i
);

  localparam int OFF   = (HAS_RVC != 0) ? 1 : 2;
  localparam int IDX_W = BP_GLOBAL_BITS + BP_LOCAL_BITS;
  localparam int DEPTH = 1 << IDX_W;

  localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

  bp_state_t        state;
  bp_state_t        state_nxt;
  logic [IDX_W-1:0] init_addr;

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] upd_idx;
  logic [1:0]       upd_val;

  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic [1:0]       wr_data;

  logic [1:0]       ram_rd_data;
  logic             run_q;
  logic             byp_hit_q;
  logic [1:0]       byp_data_q;
  logic [BP_GLOBAL_BITS-1:0] hist_q;

  // Only the index slices of the PCs matter; the rest is intentionally ignored.
  logic unused_pc;
  assign unused_pc = ^{if_parcel_pc_i, ex_pc_i};

  assign rd_idx  = {bu_bp_history_i, if_parcel_pc_i[OFF +: BP_LOCAL_BITS]};
  assign upd_idx = {bu_bp_history_update_i, ex_pc_i[OFF +: BP_LOCAL_BITS]};
  assign upd_val = bp_sat_update(bu_bp_predict_i, bu_bp_btaken_i);

  // FSM state register; reset always restarts the clear sweep from entry 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= BP_ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: leave INIT once the last entry has been written.
  always_comb begin
    state_nxt = state;
    if (state == BP_ST_INIT && init_addr == LAST_IDX) begin
      state_nxt = BP_ST_RUN;
    end
  end

  // FSM outputs: INIT owns the write port, RUN forwards resolved branches.
  always_comb begin
    bp_init_busy_o = 1'b0;
    wr_en          = 1'b0;
    wr_addr        = upd_idx;
    wr_data        = upd_val;
    if (state == BP_ST_INIT) begin
      bp_init_busy_o = 1'b1;
      wr_en          = 1'b1;
      wr_addr        = init_addr;
      wr_data        = BP_WEAK_NT;
    end else begin
      wr_en          = bu_bp_update_i;
    end
  end

  // Sweep address for the table clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      init_addr <= '0;
    end else if (state == BP_ST_INIT) begin
      init_addr <= init_addr + 1'b1;
    end
  end

  rl_ram_1r1w #(
    .AW    (IDX_W),
    .DW    (2),
    .DEPTH (DEPTH)
  ) u_table (
    .clk     (clk_i),
    .rd_en   (!id_stall_i),
    .rd_addr (rd_idx),
    .rd_data (ram_rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  // Lookup-side registers: capture bypass info and history alongside the RAM
  // read so they stay aligned, and freeze them together during a stall.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q      <= 1'b0;
      byp_hit_q  <= 1'b0;
      byp_data_q <= BP_STRONG_NT;
      hist_q     <= '0;
    end else if (!id_stall_i) begin
      run_q      <= (state == BP_ST_RUN);
      byp_hit_q  <= wr_en && (wr_addr == rd_idx);
      byp_data_q <= wr_data;
      hist_q     <= (state == BP_ST_RUN) ? bu_bp_history_i : '0;
    end
  end

  // Prediction mux: zero for lookups issued during INIT, write-first bypass
  // when the lookup collided with a write, otherwise the stored counter.
  always_comb begin
    bp_bp_predict_o = BP_STRONG_NT;
    if (run_q) begin
      bp_bp_predict_o = byp_hit_q ? byp_data_q : ram_rd_data;
    end
  end

  assign bp_bp_history_o = hist_q;

endmodule

// File: tb/tb_riscv_bp.sv
// Directed bench for riscv_bp with default parameters (DEPTH = 4096).
module tb_riscv_bp;

  localparam int DEPTH = 4096;

  logic        clk;
  logic        rst_n;
  logic        id_stall;
  logic [31:0] if_pc;
  logic [1:0]  bu_hist;
  logic [1:0]  predict;
  logic [1:0]  hist_out;
  logic        busy;
  logic [31:0] ex_pc;
  logic        upd;
  logic        btaken;
  logic [1:0]  upd_pred;
  logic [1:0]  upd_hist;

  int checks = 0;
  int errors = 0;

  riscv_bp dut (
    .rst_ni                 (rst_n),
    .clk_i                  (clk),
    .id_stall_i             (id_stall),
    .if_parcel_pc_i         (if_pc),
    .bu_bp_history_i        (bu_hist),
    .bp_bp_predict_o        (predict),
    .bp_bp_history_o        (hist_out),
    .bp_init_busy_o         (busy),
    .ex_pc_i                (ex_pc),
    .bu_bp_update_i         (upd),
    .bu_bp_btaken_i         (btaken),
    .bu_bp_predict_i        (upd_pred),
    .bu_bp_history_update_i (upd_hist)
  );

  // Clock and global time limit
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  hist;
    logic        upd;
    logic [31:0] ex_pc;
    logic [1:0]  uhist;
    logic [1:0]  upred;
    logic        taken;
    logic [1:0]  exp_pred;
    logic [1:0]  exp_hist;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input logic [31:0] pc, input logic [1:0] h,
                              input logic u, input logic [31:0] epc,
                              input logic [1:0] uh, input logic [1:0] up,
                              input logic tk, input logic [1:0] ep,
                              input logic [1:0] eh);
    vec_t v;
    v.pc = pc; v.hist = h; v.upd = u; v.ex_pc = epc; v.uhist = uh;
    v.upred = up; v.taken = tk; v.exp_pred = ep; v.exp_hist = eh;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One clock: inputs already set, outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_stall = 1'b0; if_pc = 32'h0; bu_hist = 2'd0;
    ex_pc = 32'h0; upd = 1'b0; btaken = 1'b0; upd_pred = 2'd0; upd_hist = 2'd0;
  endtask

  task automatic drive_update(input logic [31:0] pc, input logic [1:0] h,
                              input logic [1:0] p, input logic tk);
    upd = 1'b1; ex_pc = pc; upd_hist = h; upd_pred = p; btaken = tk;
  endtask

  task automatic lookup(input logic [31:0] pc, input logic [1:0] h);
    if_pc = pc; bu_hist = h;
  endtask

  // Count cycles until busy drops; an update to pc 0x10/hist 0 is issued
  // partway through and must be ignored.
  task automatic count_init(input string name);
    int n;
    n = 0;
    for (int i = 0; i < DEPTH + 100 && busy; i++) begin
      if (i == 10) chk({name, "_out_busy"}, {predict, hist_out}, 4'h0);
      if (i == 50) drive_update(32'h10, 2'd0, 2'd1, 1'b1);
      if (i == 51) upd = 1'b0;
      tick();
      n++;
    end
    chk({name, "_cycles"}, n, DEPTH);
  endtask

  initial begin
    vecs[0]  = mk(32'h100,  2'd2, 0, 32'h0,   2'd0, 2'd0, 0, 2'b01, 2'd2);
    vecs[1]  = mk(32'h200,  2'd0, 1, 32'h100, 2'd2, 2'd1, 1, 2'b01, 2'd0);
    vecs[2]  = mk(32'h100,  2'd2, 0, 32'h0,   2'd0, 2'd0, 0, 2'b10, 2'd2);
    vecs[3]  = mk(32'h104,  2'd3, 1, 32'h100, 2'd2, 2'd3, 1, 2'b01, 2'd3);
    vecs[4]  = mk(32'h100,  2'd2, 0, 32'h0,   2'd0, 2'd0, 0, 2'b11, 2'd2);
    vecs[5]  = mk(32'h300,  2'd1, 1, 32'h100, 2'd2, 2'd0, 0, 2'b01, 2'd1);
    vecs[6]  = mk(32'h100,  2'd2, 0, 32'h0,   2'd0, 2'd0, 0, 2'b00, 2'd2);
    vecs[7]  = mk(32'h100,  2'd1, 0, 32'h0,   2'd0, 2'd0, 0, 2'b01, 2'd1);
    vecs[8]  = mk(32'h180,  2'd1, 1, 32'h180, 2'd1, 2'd2, 1, 2'b11, 2'd1);
    vecs[9]  = mk(32'h180,  2'd1, 1, 32'h180, 2'd1, 2'd2, 0, 2'b01, 2'd1);
    vecs[10] = mk(32'h180,  2'd1, 0, 32'h0,   2'd0, 2'd0, 0, 2'b01, 2'd1);
    vecs[11] = mk(32'h1100, 2'd2, 0, 32'h0,   2'd0, 2'd0, 0, 2'b00, 2'd2);
    vecs[12] = mk(32'h102,  2'd2, 0, 32'h0,   2'd0, 2'd0, 0, 2'b00, 2'd2);

    // Reset state
    idle_inputs();
    rst_n = 1'b0;
    #12;
    chk("reset_predict", predict, 2'b00);
    chk("reset_history", hist_out, 2'd0);
    chk("reset_busy", busy, 1'b1);
    @(posedge clk); #1;

    // Interrupted sweep: reset at sweep address 100, then a full sweep
    rst_n = 1'b1;
    lookup(32'h40, 2'd3);
    for (int i = 0; i < 100; i++) tick();
    chk("partial_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midinit_reset_busy", busy, 1'b1);
    tick();
    rst_n = 1'b1;
    count_init("init1");
    lookup(32'h10, 2'd0);
    tick();
    chk("dropped_update", predict, 2'b01);

    // Table-driven lookup/update vectors
    foreach (vecs[i]) begin
      lookup(vecs[i].pc, vecs[i].hist);
      upd = vecs[i].upd; ex_pc = vecs[i].ex_pc; upd_hist = vecs[i].uhist;
      upd_pred = vecs[i].upred; btaken = vecs[i].taken;
      tick();
      chk($sformatf("vec%0d_predict", i), predict, vecs[i].exp_pred);
      chk($sformatf("vec%0d_history", i), hist_out, vecs[i].exp_hist);
    end
    upd = 1'b0;

    // Stall holds outputs while PC changes; a concurrent update still lands
    lookup(32'h100, 2'd2);
    tick();
    chk("prestall_predict", predict, 2'b00);
    chk("prestall_history", hist_out, 2'd2);
    id_stall = 1'b1;
    drive_update(32'h500, 2'd3, 2'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      lookup(32'h180 + 32'(i * 4), 2'(i + 1));
      tick();
      upd = 1'b0;
      chk($sformatf("stall%0d_predict", i), predict, 2'b00);
      chk($sformatf("stall%0d_history", i), hist_out, 2'd2);
    end
    id_stall = 1'b0;
    lookup(32'h500, 2'd3);
    tick();
    chk("poststall_predict", predict, 2'b10);
    chk("poststall_history", hist_out, 2'd3);

    // Reset in RUN: full re-clear, previously trained entry returns to 01
    rst_n = 1'b0;
    #1;
    chk("run_reset_predict", predict, 2'b00);
    chk("run_reset_history", hist_out, 2'd0);
    chk("run_reset_busy", busy, 1'b1);
    tick();
    rst_n = 1'b1;
    count_init("init2");
    lookup(32'h100, 2'd2);
    tick();
    chk("reinit_entry", predict, 2'b01);
    chk("reinit_history", hist_out, 2'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
